// File: rtl/crono_countdown_pkg.sv
// Shared types, BCD limits and helpers for the chronometer countdown datapath.
package crono_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAUSED  = 2'd1,
    RUNNING = 2'd2,
    EXPIRED = 2'd3
  } crono_state_t;

  localparam logic [7:0] HORA_MAX   = 8'h23;
  localparam logic [7:0] MINSEG_MAX = 8'h59;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  // Digit-wise clamp to 9 first, then clamp the 2-digit value to its field maximum.
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] s;
    s[7:4] = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    s[3:0] = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    if (s > max_v) s = max_v;
    return s;
  endfunction

endpackage

// File: rtl/crono_countdown_if.sv
// Control/data bundle between the chronometer control FSM and the countdown datapath.
interface crono_countdown_if;
  logic       ProgramarCrono;
  logic       CronoActivo;
  logic       ApagarRing;
  logic [7:0] hora_prog;
  logic [7:0] min_prog;
  logic [7:0] seg_prog;
  logic [7:0] hora_crono;
  logic [7:0] min_crono;
  logic [7:0] seg_crono;
  logic       tick_seg;
  logic       FinalizoCrono;

  modport master (
    output ProgramarCrono, CronoActivo, ApagarRing, hora_prog, min_prog, seg_prog,
    input  hora_crono, min_crono, seg_crono, tick_seg, FinalizoCrono
  );

  modport slave (
    input  ProgramarCrono, CronoActivo, ApagarRing, hora_prog, min_prog, seg_prog,
    output hora_crono, min_crono, seg_crono, tick_seg, FinalizoCrono
  );
endinterface

// File: rtl/crono_countdown_bcd_down_digit.sv
// Two-digit BCD down counter with load; wraps 00 -> max (WRAP=1) or saturates at 00.
module bcd_down_digit #(
  parameter bit WRAP = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  input  logic [7:0] i_max,
  output logic [7:0] o_value,
  output logic       o_borrow
);

  logic [7:0] r_value;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec) begin
      if (r_value == '0) begin
        if (WRAP) r_value <= i_max;
      end else if (r_value[3:0] == 4'd0) begin
        r_value <= {r_value[7:4] - 4'd1, 4'd9};
      end else begin
        r_value <= {r_value[7:4], r_value[3:0] - 4'd1};
      end
    end
  end

  assign o_value  = r_value;
  assign o_borrow = i_dec && (r_value == '0);

endmodule

// File: rtl/crono_countdown.sv
// Chronometer countdown: BCD hh:mm:ss loaded from the keypad, decremented once per TICK_DIV clocks.
// Optional macro CRONO_RING_TIMEOUT_EN: expiry self-clears after RING_SECS seconds.
module crono_countdown
  import crono_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned RING_SECS = 10
) (
  input  logic               clk,
  input  logic               Reset,
  crono_countdown_if.slave   crono
);

  localparam int unsigned PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  crono_state_t r_state;
  logic [PW-1:0] r_presc;
  logic          r_tick_seg;
  logic          r_finalizo;

`ifdef CRONO_RING_TIMEOUT_EN
  localparam int unsigned RW = $clog2(RING_SECS + 1);
  logic [RW-1:0] r_ring_cnt;
`endif

  logic [7:0] w_hora;
  logic [7:0] w_min;
  logic [7:0] w_seg;
  logic       w_time_zero;
  logic       w_time_one;
  logic       w_run_tick;
  logic       w_seg_borrow;
  logic       w_min_borrow;

  assign w_time_zero = (w_hora == 8'h00) && (w_min == 8'h00) && (w_seg == 8'h00);
  assign w_time_one  = (w_hora == 8'h00) && (w_min == 8'h00) && (w_seg == 8'h01);

  // Decrement strobe mirrors the tick branch of the FSM below so the digit
  // counters and the state register change on the same edge.
  assign w_run_tick = (r_state == RUNNING) && !crono.ProgramarCrono &&
                      crono.CronoActivo && !w_time_zero && (r_presc == PRESC_LAST);

  bcd_down_digit #(.WRAP(1'b1)) u_seg (
    .i_clk(clk), .i_rst_n(Reset), .i_load(crono.ProgramarCrono),
    .i_load_val(bcd_sanitize(crono.seg_prog, MINSEG_MAX)),
    .i_dec(w_run_tick), .i_max(MINSEG_MAX), .o_value(w_seg), .o_borrow(w_seg_borrow)
  );

  bcd_down_digit #(.WRAP(1'b1)) u_min (
    .i_clk(clk), .i_rst_n(Reset), .i_load(crono.ProgramarCrono),
    .i_load_val(bcd_sanitize(crono.min_prog, MINSEG_MAX)),
    .i_dec(w_seg_borrow), .i_max(MINSEG_MAX), .o_value(w_min), .o_borrow(w_min_borrow)
  );

  bcd_down_digit #(.WRAP(1'b0)) u_hora (
    .i_clk(clk), .i_rst_n(Reset), .i_load(crono.ProgramarCrono),
    .i_load_val(bcd_sanitize(crono.hora_prog, HORA_MAX)),
    .i_dec(w_min_borrow), .i_max(HORA_MAX), .o_value(w_hora), .o_borrow()
  );

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_presc    <= '0;
      r_tick_seg <= 1'b0;
      r_finalizo <= 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
      r_ring_cnt <= '0;
`endif
    end else begin
      r_tick_seg <= 1'b0;
      if (crono.ProgramarCrono) begin
        r_state    <= PAUSED;
        r_presc    <= '0;
        r_finalizo <= 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
        r_ring_cnt <= '0;
`endif
      end else begin
        case (r_state)
          IDLE, PAUSED: begin
            if (crono.CronoActivo) r_state <= RUNNING;
          end
          RUNNING: begin
            if (!crono.CronoActivo) begin
              r_state <= PAUSED;
            end else if (w_time_zero) begin
              r_state    <= EXPIRED;
              r_finalizo <= 1'b1;
            end else if (r_presc == PRESC_LAST) begin
              r_presc    <= '0;
              r_tick_seg <= 1'b1;
              if (w_time_one) begin
                r_state    <= EXPIRED;
                r_finalizo <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          EXPIRED: begin
            if (crono.ApagarRing) begin
              r_state    <= IDLE;
              r_finalizo <= 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
              r_ring_cnt <= '0;
            end else if (r_presc == PRESC_LAST) begin
              r_presc <= '0;
              if (r_ring_cnt == RW'(RING_SECS - 1)) begin
                r_state    <= IDLE;
                r_finalizo <= 1'b0;
                r_ring_cnt <= '0;
              end else begin
                r_ring_cnt <= r_ring_cnt + RW'(1);
              end
            end else begin
              r_presc <= r_presc + PW'(1);
`endif
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign crono.hora_crono    = w_hora;
  assign crono.min_crono     = w_min;
  assign crono.seg_crono     = w_seg;
  assign crono.tick_seg      = r_tick_seg;
  assign crono.FinalizoCrono = r_finalizo;

endmodule

// File: tb/tb_crono_countdown.sv
// Directed self-checking bench for crono_countdown (TICK_DIV=4, RING_SECS=3).
module tb_crono_countdown;
  import crono_pkg::*;

  logic clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  crono_countdown_if bus_if ();

  crono_countdown #(.TICK_DIV(4), .RING_SECS(3)) dut (
    .clk(clk),
    .Reset(Reset),
    .crono(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus_if.hora_prog      = h;
    bus_if.min_prog       = m;
    bus_if.seg_prog       = s;
    bus_if.ProgramarCrono = 1'b1;
    step(1);
    bus_if.ProgramarCrono = 1'b0;
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({tag, "_h"}, 32'(bus_if.hora_crono), 32'(h));
    chk({tag, "_m"}, 32'(bus_if.min_crono), 32'(m));
    chk({tag, "_s"}, 32'(bus_if.seg_crono), 32'(s));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b0;
    bus_if.ProgramarCrono = 1'b0;
    bus_if.CronoActivo    = 1'b0;
    bus_if.ApagarRing     = 1'b0;
    bus_if.hora_prog      = 8'h00;
    bus_if.min_prog       = 8'h00;
    bus_if.seg_prog       = 8'h00;

    // Reset state
    step(2);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    chk_time("rst", 8'h00, 8'h00, 8'h00);
    chk("rst_tick", 32'(bus_if.tick_seg), 32'd0);
    chk("rst_fin", 32'(bus_if.FinalizoCrono), 32'd0);
    Reset = 1'b1;
    step(1);

    // 00:00:03 countdown, tick every 4 clk, expiry on third tick
    load(8'h00, 8'h00, 8'h03);
    chk("ld3_state", 32'(dut.r_state), 32'(PAUSED));
    chk_time("ld3", 8'h00, 8'h00, 8'h03);
    bus_if.ApagarRing = 1'b1;
    step(1);
    bus_if.ApagarRing = 1'b0;
    chk("apagar_paused", 32'(dut.r_state), 32'(PAUSED));
    bus_if.CronoActivo = 1'b1;
    step(1);
    chk("run_state", 32'(dut.r_state), 32'(RUNNING));
    step(3);
    chk("pre_tick1", 32'(bus_if.tick_seg), 32'd0);
    chk("pre_tick1_s", 32'(bus_if.seg_crono), 32'h03);
    step(1);
    chk("tick1", 32'(bus_if.tick_seg), 32'd1);
    chk("tick1_s", 32'(bus_if.seg_crono), 32'h02);
    step(1);
    chk("tick1_pulse", 32'(bus_if.tick_seg), 32'd0);
    step(3);
    chk("tick2", 32'(bus_if.tick_seg), 32'd1);
    chk("tick2_s", 32'(bus_if.seg_crono), 32'h01);
    chk("tick2_fin", 32'(bus_if.FinalizoCrono), 32'd0);
    step(4);
    chk("tick3", 32'(bus_if.tick_seg), 32'd1);
    chk_time("tick3", 8'h00, 8'h00, 8'h00);
    chk("tick3_fin", 32'(bus_if.FinalizoCrono), 32'd1);
    chk("tick3_state", 32'(dut.r_state), 32'(EXPIRED));
    bus_if.CronoActivo = 1'b0;
`ifdef CRONO_RING_TIMEOUT_EN
    step(11);
    chk("ring_hold", 32'(bus_if.FinalizoCrono), 32'd1);
    chk("ring_tick0", 32'(bus_if.tick_seg), 32'd0);
    step(1);
    chk("ring_clear", 32'(bus_if.FinalizoCrono), 32'd0);
    chk("ring_state", 32'(dut.r_state), 32'(IDLE));
`else
    step(12);
    chk("exp_hold", 32'(bus_if.FinalizoCrono), 32'd1);
    chk("exp_tick0", 32'(bus_if.tick_seg), 32'd0);
    chk_time("exp_frozen", 8'h00, 8'h00, 8'h00);
    bus_if.ApagarRing = 1'b1;
    step(1);
    bus_if.ApagarRing = 1'b0;
    chk("ack_fin", 32'(bus_if.FinalizoCrono), 32'd0);
    chk("ack_state", 32'(dut.r_state), 32'(IDLE));
`endif

    // Full borrow chain 01:00:00 -> 00:59:59
    load(8'h01, 8'h00, 8'h00);
    bus_if.CronoActivo = 1'b1;
    step(5);
    chk("borrow_tick", 32'(bus_if.tick_seg), 32'd1);
    chk_time("borrow", 8'h00, 8'h59, 8'h59);
    bus_if.CronoActivo = 1'b0;

    // Pause at prescaler 2 for 10 clk; prescaler holds across the pause
    load(8'h00, 8'h00, 8'h05);
    bus_if.CronoActivo = 1'b1;
    step(3);
    chk("pause_presc", 32'(dut.r_presc), 32'd2);
    bus_if.CronoActivo = 1'b0;
    step(10);
    chk("pause_state", 32'(dut.r_state), 32'(PAUSED));
    chk("pause_hold", 32'(dut.r_presc), 32'd2);
    chk("pause_s", 32'(bus_if.seg_crono), 32'h05);
    bus_if.CronoActivo = 1'b1;
    step(2);
    chk("resume_notick", 32'(bus_if.tick_seg), 32'd0);
    step(1);
    chk("resume_tick", 32'(bus_if.tick_seg), 32'd1);
    chk("resume_s", 32'(bus_if.seg_crono), 32'h04);
    bus_if.CronoActivo = 1'b0;

    // Load and ApagarRing together while EXPIRED: load wins
    load(8'h00, 8'h00, 8'h01);
    bus_if.CronoActivo = 1'b1;
    step(5);
    chk("exp2_fin", 32'(bus_if.FinalizoCrono), 32'd1);
    bus_if.CronoActivo    = 1'b0;
    bus_if.ApagarRing     = 1'b1;
    bus_if.hora_prog      = 8'h00;
    bus_if.min_prog       = 8'h02;
    bus_if.seg_prog       = 8'h30;
    bus_if.ProgramarCrono = 1'b1;
    step(1);
    bus_if.ProgramarCrono = 1'b0;
    bus_if.ApagarRing     = 1'b0;
    chk_time("prio", 8'h00, 8'h02, 8'h30);
    chk("prio_state", 32'(dut.r_state), 32'(PAUSED));
    chk("prio_fin", 32'(bus_if.FinalizoCrono), 32'd0);

    // Sanitising, and ProgramarCrono held high keeps PAUSED despite CronoActivo
    bus_if.CronoActivo = 1'b1;
    bus_if.hora_prog      = 8'h31;
    bus_if.min_prog       = 8'h5C;
    bus_if.seg_prog       = 8'h7A;
    bus_if.ProgramarCrono = 1'b1;
    step(3);
    chk_time("sanit", 8'h23, 8'h59, 8'h59);
    chk("hold_prog_state", 32'(dut.r_state), 32'(PAUSED));
    bus_if.ProgramarCrono = 1'b0;
    bus_if.CronoActivo    = 1'b0;

    // Running with 00:00:00 loaded expires on the next edge without a tick
    load(8'h00, 8'h00, 8'h00);
    bus_if.CronoActivo = 1'b1;
    step(1);
    chk("zero_run", 32'(dut.r_state), 32'(RUNNING));
    step(1);
    chk("zero_exp", 32'(dut.r_state), 32'(EXPIRED));
    chk("zero_fin", 32'(bus_if.FinalizoCrono), 32'd1);
    chk("zero_tick", 32'(bus_if.tick_seg), 32'd0);
    bus_if.CronoActivo = 1'b0;
    bus_if.ApagarRing  = 1'b1;
    step(1);
    bus_if.ApagarRing  = 1'b0;
    chk("zero_ack", 32'(bus_if.FinalizoCrono), 32'd0);

    // Reset mid-count
    load(8'h00, 8'h10, 8'h20);
    bus_if.CronoActivo = 1'b1;
    step(3);
    Reset = 1'b0;
    step(1);
    chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
    chk_time("mid_rst", 8'h00, 8'h00, 8'h00);
    chk("mid_rst_presc", 32'(dut.r_presc), 32'd0);
    chk("mid_rst_fin", 32'(bus_if.FinalizoCrono), 32'd0);
    Reset = 1'b1;
    bus_if.CronoActivo = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
